// File: rtl/mem_requester.sv
// Memory-side request sequencer: turns one READ/WRITE/FILL/COPY command into a
// cycle-by-cycle sequence on a single-port, combinational-read word memory.
module mem_requester #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [1:0]            reqOp,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [ADDR_WIDTH-1:0] reqAddr2,
    input  logic [DATA_WIDTH-1:0] reqData,
    input  logic [15:0]           reqCount,
    output logic                  respValid,
    output logic [DATA_WIDTH-1:0] respData,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memWriteEnable,
    output logic [DATA_WIDTH-1:0] memDataOut,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    output logic [2:0]            debug_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FILL = 3'd3,
        S_CPRD = 3'd4,
        S_CPWR = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] dst;
    logic [15:0]           rem;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [DATA_WIDTH-1:0] resp_data_q;

    // Handshake: a command is taken on a rising edge where reqValid && reqReady;
    // reqReady is high only in IDLE outside reset, and reqValid is ignored otherwise.
    assign reqReady       = (state == S_IDLE) && reset;
    assign respValid      = (state == S_DONE);
    assign busy           = (state != S_IDLE);
    assign memWriteEnable = reset && ((state == S_WR) || (state == S_FILL) || (state == S_CPWR));
    assign memAddress     = mem_address_q;
    assign memDataOut     = mem_data_q;
    assign respData       = resp_data_q;
    assign debug_state    = state;

    // Address/data registers are loaded one edge ahead of the access state so the
    // memory port is a pure function of registered state and otherwise holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            cur           <= '0;
            dst           <= '0;
            rem           <= '0;
            data          <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            resp_data_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (reqValid) begin
                        cur  <= reqAddr;
                        dst  <= reqAddr2;
                        rem  <= reqCount;
                        data <= reqData;
                        case (reqOp)
                            2'b00: begin
                                state         <= S_RD;
                                mem_address_q <= reqAddr;
                            end
                            2'b01: begin
                                state         <= S_WR;
                                mem_address_q <= reqAddr;
                                mem_data_q    <= reqData;
                            end
                            2'b10: begin
                                if (reqCount != 16'd0) begin
                                    state         <= S_FILL;
                                    mem_address_q <= reqAddr;
                                    mem_data_q    <= reqData;
                                end else begin
                                    state <= S_DONE;
                                end
                            end
                            default: begin
                                if (reqCount != 16'd0) begin
                                    state         <= S_CPRD;
                                    mem_address_q <= reqAddr;
                                end else begin
                                    state <= S_DONE;
                                end
                            end
                        endcase
                    end
                end
                S_RD: begin
                    resp_data_q <= memDataIn;
                    state       <= S_DONE;
                end
                S_WR: begin
                    resp_data_q <= data;
                    state       <= S_DONE;
                end
                S_FILL: begin
                    cur         <= cur + ADDR_ONE;
                    rem         <= rem - 16'd1;
                    resp_data_q <= data;
                    if (rem == 16'd1) begin
                        state <= S_DONE;
                    end else begin
                        mem_address_q <= cur + ADDR_ONE;
                    end
                end
                S_CPRD: begin
                    // The write-data register doubles as the copy buffer.
                    mem_data_q    <= memDataIn;
                    mem_address_q <= dst;
                    state         <= S_CPWR;
                end
                S_CPWR: begin
                    cur         <= cur + ADDR_ONE;
                    dst         <= dst + ADDR_ONE;
                    rem         <= rem - 16'd1;
                    resp_data_q <= mem_data_q;
                    if (rem == 16'd1) begin
                        state <= S_DONE;
                    end else begin
                        mem_address_q <= cur + ADDR_ONE;
                        state         <= S_CPRD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
